// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame width and the
// tick-divider derivation reused by the TX side.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_e;

    localparam int DATA_BITS = 8;

    function automatic int calc_tick_div(
        input int clk_freq,
        input int baud,
        input int os
    );
        return clk_freq / (baud * os);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle tick every DIV cycles;
// clr_i holds it at phase zero.
module uart_baud_tick #(
    parameter int DIV = 13
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST) && !clr_i;

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (clr_i || tick_o)
            cnt_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-flop synchronizer, oversampled mid-bit sampling,
// one-cycle valid / frame-error strobes.
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 1000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       RXD_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       frame_err_o,
    output logic       rx_busy_o
);

    localparam int TICK_DIV = calc_tick_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);

    state_e         state_q, state_d;
    logic           rxd_meta_q, rxd_s_q;
    logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]     shreg_q, shreg_d;
    logic [7:0]     data_q, data_d;
    logic           valid_q, valid_d;
    logic           ferr_q, ferr_d;
    logic           tick;
    logic           mid_hit, last_hit;

    uart_baud_tick #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (state_q == IDLE),
        .tick_o (tick)
    );

    assign mid_hit  = tick && (tick_cnt_q == MID);
    assign last_hit = tick && (tick_cnt_q == LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rxd_meta_q <= RXD_i;
            rxd_s_q    <= rxd_meta_q;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!rxd_s_q) state_d = START;
            START:   if (mid_hit) state_d = rxd_s_q ? IDLE : DATA;
            DATA:    if (last_hit && bit_cnt_q == BLAST) state_d = STOP;
            STOP:    if (last_hit) state_d = rxd_s_q ? IDLE : BREAK;
            BREAK:   if (rxd_s_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tick_cnt_d = tick ? tick_cnt_q + TW'(1) : tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
            end
            START: begin
                // Restart the bit grid at mid start bit.
                if (mid_hit) begin
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            DATA: begin
                if (last_hit) begin
                    shreg_d   = {rxd_s_q, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            STOP: begin
                if (last_hit) begin
                    if (rxd_s_q) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            BREAK:   tick_cnt_d = '0;
            default: tick_cnt_d = '0;
        endcase
    end

    assign rx_data_o   = data_q;
    assign rx_valid_o  = valid_q;
    assign frame_err_o = ferr_q;
    assign rx_busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Scoreboard bench for uart_rx_8n1: stimulus queues expected strobes,
// a negedge monitor pops and checks them.
module tb_uart_rx_8n1;

    typedef struct {
        bit       err;
        bit [7:0] data;
        bit       chk_gap;
        bit       chk_lat;
        int       t0;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    exp_t sb[$];
    int   vectors;
    int   miscompares;
    int   cyc;

    uart_rx_8n1 dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .RXD_i       (rxd),
        .rx_data_o   (rx_data),
        .rx_valid_o  (rx_valid),
        .frame_err_o (frame_err),
        .rx_busy_o   (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        rxd = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int bp,
                              input logic stop, input bit gap);
        exp_t e;
        e.err     = !stop;
        e.data    = d;
        e.chk_gap = gap;
        e.chk_lat = (bp == 104);
        e.t0      = cyc;
        sb.push_back(e);
        drive(1'b0, bp);
        for (int i = 0; i < 8; i++)
            drive(d[i], bp);
        drive(stop, bp);
    endtask

    // Monitor
    initial begin
        exp_t e;
        int   last_v;
        int   lat;
        logic prev_busy;
        last_v    = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_valid && frame_err) begin
                vectors++;
                miscompares++;
                $display("FAIL exclusive: valid=1 frame_err=1 both high");
            end
            if (rx_valid || frame_err) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_strobe: valid=%0b err=%0b expected none",
                             rx_valid, frame_err);
                end else begin
                    e = sb.pop_front();
                    check("strobe_kind", {31'd0, frame_err}, {31'd0, e.err});
                    if (!e.err) begin
                        check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                        check("busy_fall", {30'd0, prev_busy, rx_busy}, 32'd2);
                        if (e.chk_gap) begin
                            vectors++;
                            if ((cyc - last_v) < 1039 || (cyc - last_v) > 1041) begin
                                miscompares++;
                                $display("FAIL gap: got %0d expected 1040", cyc - last_v);
                            end
                        end
                        last_v = cyc;
                    end
                    if (e.chk_lat) begin
                        lat = cyc - e.t0;
                        vectors++;
                        if (lat < 989 || lat > 991) begin
                            miscompares++;
                            $display("FAIL latency: got %0d expected 990+-1", lat);
                        end
                    end
                end
            end
            prev_busy = rx_busy;
        end
    end

    // Stimulus
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", {24'd0, rx_data}, 32'h0);
        check("rst_valid", {31'd0, rx_valid}, 32'h0);
        check("rst_ferr", {31'd0, frame_err}, 32'h0);
        check("rst_busy", {31'd0, rx_busy}, 32'h0);
        rst = 1'b0;
        drive(1'b1, 20);

        send_frame(8'h55, 104, 1'b1, 1'b0);
        drive(1'b1, 20);

        send_frame(8'h00, 104, 1'b1, 1'b0);
        send_frame(8'hFF, 104, 1'b1, 1'b1);
        send_frame(8'hA5, 104, 1'b1, 1'b1);
        drive(1'b1, 20);

        drive(1'b0, 30);
        drive(1'b1, 100);
        check("glitch_busy", {31'd0, rx_busy}, 32'h0);
        check("glitch_data", {24'd0, rx_data}, 32'hA5);

        send_frame(8'h3C, 104, 1'b0, 1'b0);
        drive(1'b0, 500);
        drive(1'b1, 20);
        check("ferr_busy", {31'd0, rx_busy}, 32'h0);
        check("ferr_data", {24'd0, rx_data}, 32'hA5);
        send_frame(8'h81, 104, 1'b1, 1'b0);
        drive(1'b1, 20);

        // 0xF3: bits 4..7 and stop high, so nothing follows the reset
        drive(1'b0, 104);
        drive(1'b1, 104);
        drive(1'b1, 104);
        drive(1'b0, 104);
        drive(1'b0, 104);
        drive(1'b1, 50);
        check("pre_rst_busy", {31'd0, rx_busy}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_data", {24'd0, rx_data}, 32'h0);
        check("mid_rst_busy", {31'd0, rx_busy}, 32'h0);
        check("mid_rst_valid", {31'd0, rx_valid}, 32'h0);
        check("mid_rst_ferr", {31'd0, frame_err}, 32'h0);
        drive(1'b1, 54 + 4 * 104 + 100);
        check("post_rst_data", {24'd0, rx_data}, 32'h0);
        send_frame(8'h12, 104, 1'b1, 1'b0);
        drive(1'b1, 20);

        send_frame(8'hC3, 102, 1'b1, 1'b0);
        drive(1'b1, 50);
        send_frame(8'hC3, 106, 1'b1, 1'b0);
        drive(1'b1, 50);

        for (int i = 0; i < 3000 && sb.size() != 0; i++)
            @(negedge clk);
        check("pending_strobes", sb.size(), 32'd0);
        check("final_busy", {31'd0, rx_busy}, 32'h0);
        check("final_data", {24'd0, rx_data}, 32'hC3);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
